// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the CPU/VDP RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned STARVE_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VDP  = 2'd2
    } owner_e;

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: VDP fixed priority, bounded CPU starvation,
// three-stage arbitrate/issue/response pipeline with a 2-cycle req->ack latency.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vdp_req,
    input  logic [ADDR_W-1:0] vdp_addr,
    output logic              vdp_ack,
    output logic [DATA_W-1:0] vdp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

    owner_e              iss_own_q, iss_own_d;
    owner_e              rsp_own_q, rsp_own_d;
    owner_e              win_c;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   vdp_rdata_q, vdp_rdata_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                cpu_elig_c, vdp_elig_c;

    // Arbitration, issue capture, response capture and starvation tracking.
    always_comb begin
        iss_own_d   = OWN_NONE;
        rsp_own_d   = iss_own_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vdp_rdata_d = vdp_rdata_q;
        starve_d    = starve_q;
        win_c       = OWN_NONE;

        // A requester with an access in issue or response is masked.
        cpu_elig_c = cpu_req && (iss_own_q != OWN_CPU) && (rsp_own_q != OWN_CPU);
        vdp_elig_c = vdp_req && (iss_own_q != OWN_VDP) && (rsp_own_q != OWN_VDP);

        if (cpu_elig_c && vdp_elig_c) begin
            win_c = (starve_q == LIMIT_C) ? OWN_CPU : OWN_VDP;
        end else if (cpu_elig_c) begin
            win_c = OWN_CPU;
        end else if (vdp_elig_c) begin
            win_c = OWN_VDP;
        end

        iss_own_d = win_c;
        case (win_c)
            OWN_CPU: begin
                mem_addr_d = cpu_addr;
                starve_d   = '0;
                if (cpu_we) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = cpu_wdata;
                end
            end
            OWN_VDP: begin
                mem_addr_d = vdp_addr;
                if (cpu_elig_c && (starve_q != LIMIT_C)) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            default: ;
        endcase

        if (iss_own_q == OWN_CPU && !mem_we_q) begin
            cpu_rdata_d = mem_rdata;
        end else if (iss_own_q == OWN_VDP) begin
            vdp_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_own_q   <= OWN_NONE;
            rsp_own_q   <= OWN_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            vdp_rdata_q <= '0;
            starve_q    <= '0;
        end else begin
            iss_own_q   <= iss_own_d;
            rsp_own_q   <= rsp_own_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_rdata_q <= cpu_rdata_d;
            vdp_rdata_q <= vdp_rdata_d;
            starve_q    <= starve_d;
        end
    end

    assign cpu_ack   = (rsp_own_q == OWN_CPU);
    assign vdp_ack   = (rsp_own_q == OWN_VDP);
    assign cpu_rdata = cpu_rdata_q;
    assign vdp_rdata = vdp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed cycle table, then random traffic against a
// grant-time reference model with its own shadow memory.
module tb_ram_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, vdp_req;
    logic [15:0] cpu_addr, vdp_addr, mem_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, vdp_rdata, mem_wdata, mem_rdata;
    logic        cpu_ack, vdp_ack, mem_we;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vdp_req(vdp_req), .vdp_addr(vdp_addr), .vdp_ack(vdp_ack), .vdp_rdata(vdp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        case (a)
            16'h0200: return 8'h5A;
            16'h1000: return 8'h11;
            16'h2000: return 8'h22;
            default:  return a[7:0] ^ a[15:8] ^ 8'h3C;
        endcase
    endfunction

    // RAM macro: data for the presented address visible in the issue cycle.
    logic [7:0] ram  [0:65535];
    bit         ramv [0:65535];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]  <= mem_wdata;
            ramv[mem_addr] <= 1'b1;
        end
    end
    assign mem_rdata = ramv[mem_addr] ? ram[mem_addr] : init_val(mem_addr);

    // Reference model state: grant cycles per requester, shadow memory.
    typedef struct { int own; logic we; logic [15:0] addr; logic [7:0] wd; } acc_t;
    logic [7:0] sh  [0:65535];
    bit         shv [0:65535];
    int         cyc, cpu_g, vdp_g, starve;
    acc_t       iss;
    logic [15:0] e_addr;
    logic [7:0]  e_wd, e_crd, e_vrd;
    logic        e_we, e_cack, e_vack;
    bit          m_cpu_won, m_vdp_won;
    int          vectors, miscompares;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        cpu_g = -100; vdp_g = -100; starve = 0;
        iss = '{0, 1'b0, 16'h0, 8'h0};
        e_addr = '0; e_wd = '0; e_crd = '0; e_vrd = '0;
        e_we = 1'b0; e_cack = 1'b0; e_vack = 1'b0;
    endtask

    task automatic step();
        acc_t g;
        bit   ce, ve, r;
        int   win;
        r = reset;
        m_cpu_won = 1'b0; m_vdp_won = 1'b0;
        g = '{0, 1'b0, e_addr, e_wd};
        if (!r) begin
            ce  = cpu_req && (cyc - cpu_g >= 3);
            ve  = vdp_req && (cyc - vdp_g >= 3);
            win = 0;
            if (ce && ve) win = (starve == LIMIT) ? 1 : 2;
            else if (ce)  win = 1;
            else if (ve)  win = 2;
            if (win == 1) begin
                starve = 0; cpu_g = cyc; m_cpu_won = 1'b1;
                g = '{1, cpu_we, cpu_addr, cpu_we ? cpu_wdata : e_wd};
            end else if (win == 2) begin
                if (ce && starve < LIMIT) starve++;
                vdp_g = cyc; m_vdp_won = 1'b1;
                g = '{2, 1'b0, vdp_addr, e_wd};
            end
            // Complete the access being presented to the RAM this cycle.
            if (iss.own == 1 && iss.we) begin
                sh[iss.addr] = iss.wd; shv[iss.addr] = 1'b1;
            end else if (iss.own == 1) begin
                e_crd = shv[iss.addr] ? sh[iss.addr] : init_val(iss.addr);
            end else if (iss.own == 2) begin
                e_vrd = shv[iss.addr] ? sh[iss.addr] : init_val(iss.addr);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            model_reset();
        end else begin
            e_addr = g.addr; e_wd = g.wd; e_we = (g.own == 1) && g.we;
            e_cack = (cyc == cpu_g + 2); e_vack = (cyc == vdp_g + 2);
            iss = g;
        end
        chk("cpu_ack",   16'(cpu_ack),   16'(e_cack));
        chk("vdp_ack",   16'(vdp_ack),   16'(e_vack));
        chk("mem_we",    16'(mem_we),    16'(e_we));
        chk("mem_addr",  mem_addr,       e_addr);
        chk("mem_wdata", 16'(mem_wdata), 16'(e_wd));
        chk("cpu_rdata", 16'(cpu_rdata), 16'(e_crd));
        chk("vdp_rdata", 16'(vdp_rdata), 16'(e_vrd));
    endtask

    typedef struct {
        logic rst, creq, cwe; logic [15:0] caddr; logic [7:0] cwd;
        logic vreq; logic [15:0] vaddr;
        logic e_cack, e_vack, e_we; logic [15:0] e_addr; logic [7:0] e_wd, e_crd, e_vrd;
    } vec_t;

    function automatic vec_t mk(input logic rst, creq, cwe, input logic [15:0] caddr,
                                input logic [7:0] cwd, input logic vreq, input logic [15:0] vaddr,
                                input logic ca, va, we, input logic [15:0] ad,
                                input logic [7:0] wd, crd, vrd);
        vec_t v;
        v = '{rst, creq, cwe, caddr, cwd, vreq, vaddr, ca, va, we, ad, wd, crd, vrd};
        return v;
    endfunction

    vec_t tbl [26];
    bit   ch, cg, vh, vg;

    initial begin
        // Each row: inputs for one cycle, outputs expected after its edge.
        tbl[0]  = mk(1,0,0,16'h0000,8'h00,0,16'h0000, 0,0,0,16'h0000,8'h00,8'h00,8'h00);
        tbl[1]  = mk(0,1,0,16'h0200,8'h00,0,16'h0000, 0,0,0,16'h0200,8'h00,8'h00,8'h00);
        tbl[2]  = mk(0,1,0,16'h0200,8'h00,0,16'h0000, 1,0,0,16'h0200,8'h00,8'h5A,8'h00);
        tbl[3]  = mk(0,1,0,16'h0200,8'h00,0,16'h0000, 0,0,0,16'h0200,8'h00,8'h5A,8'h00);
        tbl[4]  = mk(0,1,0,16'h0200,8'h00,0,16'h0000, 0,0,0,16'h0200,8'h00,8'h5A,8'h00);
        tbl[5]  = mk(0,0,0,16'h0200,8'h00,0,16'h0000, 1,0,0,16'h0200,8'h00,8'h5A,8'h00);
        tbl[6]  = mk(0,0,0,16'h0200,8'h00,0,16'h0000, 0,0,0,16'h0200,8'h00,8'h5A,8'h00);
        tbl[7]  = mk(0,1,1,16'h8000,8'hC3,0,16'h0000, 0,0,1,16'h8000,8'hC3,8'h5A,8'h00);
        tbl[8]  = mk(0,1,1,16'h8000,8'hC3,0,16'h0000, 1,0,0,16'h8000,8'hC3,8'h5A,8'h00);
        tbl[9]  = mk(0,0,0,16'h8000,8'h00,0,16'h0000, 0,0,0,16'h8000,8'hC3,8'h5A,8'h00);
        tbl[10] = mk(0,1,0,16'h8000,8'h00,0,16'h0000, 0,0,0,16'h8000,8'hC3,8'h5A,8'h00);
        tbl[11] = mk(0,0,0,16'h8000,8'h00,0,16'h0000, 1,0,0,16'h8000,8'hC3,8'hC3,8'h00);
        tbl[12] = mk(0,0,0,16'h8000,8'h00,0,16'h0000, 0,0,0,16'h8000,8'hC3,8'hC3,8'h00);
        tbl[13] = mk(0,1,0,16'h2000,8'h00,1,16'h1000, 0,0,0,16'h1000,8'hC3,8'hC3,8'h00);
        tbl[14] = mk(0,1,0,16'h2000,8'h00,1,16'h1000, 0,1,0,16'h2000,8'hC3,8'hC3,8'h11);
        tbl[15] = mk(0,0,0,16'h2000,8'h00,0,16'h1000, 1,0,0,16'h2000,8'hC3,8'h22,8'h11);
        tbl[16] = mk(0,0,0,16'h2000,8'h00,0,16'h1000, 0,0,0,16'h2000,8'hC3,8'h22,8'h11);
        tbl[17] = mk(0,1,0,16'h0300,8'h00,1,16'h1000, 0,0,0,16'h1000,8'hC3,8'h22,8'h11);
        tbl[18] = mk(0,0,0,16'h0300,8'h00,0,16'h1000, 0,1,0,16'h1000,8'hC3,8'h22,8'h11);
        tbl[19] = mk(0,0,0,16'h0300,8'h00,0,16'h1000, 0,0,0,16'h1000,8'hC3,8'h22,8'h11);
        tbl[20] = mk(0,0,0,16'h0300,8'h00,0,16'h1000, 0,0,0,16'h1000,8'hC3,8'h22,8'h11);
        tbl[21] = mk(0,1,0,16'h0200,8'h00,0,16'h1000, 0,0,0,16'h0200,8'hC3,8'h22,8'h11);
        tbl[22] = mk(1,1,0,16'h0200,8'h00,0,16'h1000, 0,0,0,16'h0000,8'h00,8'h00,8'h00);
        tbl[23] = mk(0,1,0,16'h0200,8'h00,0,16'h1000, 0,0,0,16'h0200,8'h00,8'h00,8'h00);
        tbl[24] = mk(0,1,0,16'h0200,8'h00,0,16'h1000, 1,0,0,16'h0200,8'h00,8'h5A,8'h00);
        tbl[25] = mk(0,0,0,16'h0200,8'h00,0,16'h1000, 0,0,0,16'h0200,8'h00,8'h5A,8'h00);

        vectors = 0; miscompares = 0; cyc = 0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vdp_req = 1'b0; vdp_addr = '0;
        model_reset();

        for (int i = 0; i < 26; i++) begin
            reset = tbl[i].rst; cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe;
            cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
            vdp_req = tbl[i].vreq; vdp_addr = tbl[i].vaddr;
            step();
            chk("tbl_cpu_ack",   16'(cpu_ack),   16'(tbl[i].e_cack));
            chk("tbl_vdp_ack",   16'(vdp_ack),   16'(tbl[i].e_vack));
            chk("tbl_mem_we",    16'(mem_we),    16'(tbl[i].e_we));
            chk("tbl_mem_addr",  mem_addr,       tbl[i].e_addr);
            chk("tbl_mem_wdata", 16'(mem_wdata), 16'(tbl[i].e_wd));
            chk("tbl_cpu_rdata", 16'(cpu_rdata), 16'(tbl[i].e_crd));
            chk("tbl_vdp_rdata", 16'(vdp_rdata), 16'(tbl[i].e_vrd));
        end

        // Both requesters held continuously: interleaving and starvation bound.
        reset = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h2000; vdp_addr = 16'h1000;
        cpu_req = 1'b1; vdp_req = 1'b1;
        for (int i = 0; i < 15; i++) step();
        cpu_req = 1'b0; vdp_req = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Random protocol-legal traffic with occasional withdrawals and resets.
        ch = 1'b0; cg = 1'b0; vh = 1'b0; vg = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (ch && !cg && $urandom_range(0, 15) == 0) ch = 1'b0;
            if (!ch && !cg && $urandom_range(0, 2) == 0) begin
                ch = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'h4000 | 16'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
            if (vh && !vg && $urandom_range(0, 15) == 0) vh = 1'b0;
            if (!vh && !vg && $urandom_range(0, 1) == 0) begin
                vh = 1'b1;
                vdp_addr = 16'h4000 | 16'($urandom_range(0, 15));
            end
            cpu_req = ch; vdp_req = vh;
            step();
            if (reset) begin
                cg = 1'b0; vg = 1'b0;
            end else begin
                if (m_cpu_won) cg = 1'b1;
                if (m_vdp_won) vg = 1'b1;
                if (e_cack) begin cg = 1'b0; ch = 1'b0; end
                if (e_vack) begin vg = 1'b0; vh = 1'b0; end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
